// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, a one-entry skid buffer
// behind the IF/ID register, redirect (with drain of an in-flight request) and HALT stop.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        id_valid,
  output logic [15:0] id_instr,
  output logic [4:0]  id_opcode,
  output logic [1:0]  id_funcode,
  output logic [15:0] id_pc_plus2,
  output logic        halted
);

  localparam int unsigned XLEN = 16;
  localparam int unsigned OPW  = 5;
  localparam logic [OPW-1:0] OP_HALT = '0;

  typedef enum logic [2:0] {
    S_START = 3'd0,
    S_FETCH = 3'd1,
    S_HOLD  = 3'd2,
    S_DRAIN = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  state_e state_q, state_nx;

  logic [XLEN-1:0] pc_q, pc_nx;
  logic [XLEN-1:0] pending_q, pending_nx;
  logic            skid_valid_q, skid_valid_nx;
  logic [XLEN-1:0] skid_instr_q, skid_instr_nx;
  logic [XLEN-1:0] skid_pc2_q, skid_pc2_nx;
  logic            id_valid_nx;
  logic [XLEN-1:0] id_instr_nx;
  logic [XLEN-1:0] id_pc_plus2_nx;
  logic            halted_nx;
  logic            imem_req_nx;
  logic [XLEN-1:0] imem_addr_nx;

  logic            slot_free;
  logic            rdata_halt;
  logic            skid_halt;
  logic [XLEN-1:0] pc_plus2;
  logic [XLEN-1:0] redirect_tgt;

  assign slot_free    = !id_valid || !stall;
  assign pc_plus2     = pc_q + XLEN'(2);
  assign redirect_tgt = redirect_pc & ~XLEN'(1);
  assign rdata_halt   = imem_rdata[15:11] == OP_HALT;
  assign skid_halt    = skid_instr_q[15:11] == OP_HALT;
  assign id_opcode    = id_instr[15:11];
  assign id_funcode   = id_instr[1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_START;
    else        state_q <= state_nx;
  end

  // Next-state logic; redirect outranks everything else
  always_comb begin
    state_nx = state_q;
    unique case (state_q)
      S_START: state_nx = S_FETCH;
      S_FETCH: begin
        if (redirect) begin
          state_nx = imem_valid ? S_FETCH : S_DRAIN;
        end else if (imem_valid) begin
          if (!slot_free)      state_nx = S_HOLD;
          else if (rdata_halt) state_nx = S_HALT;
        end
      end
      S_HOLD: begin
        if (redirect) state_nx = S_FETCH;
        else if (slot_free && skid_valid_q) state_nx = skid_halt ? S_HALT : S_FETCH;
      end
      S_DRAIN: if (imem_valid) state_nx = S_FETCH;
      S_HALT:  if (redirect) state_nx = S_FETCH;
      default: state_nx = S_START;
    endcase
  end

  // Next values of the datapath and of the registered outputs
  always_comb begin
    pc_nx          = pc_q;
    pending_nx     = pending_q;
    skid_valid_nx  = skid_valid_q;
    skid_instr_nx  = skid_instr_q;
    skid_pc2_nx    = skid_pc2_q;
    id_valid_nx    = id_valid;
    id_instr_nx    = id_instr;
    id_pc_plus2_nx = id_pc_plus2;
    if (redirect) begin
      id_valid_nx   = 1'b0;
      id_instr_nx   = NOP_INSTR;
      skid_valid_nx = 1'b0;
      // An unfinished request must still complete, so park the target until it does
      if ((state_q inside {S_FETCH, S_DRAIN}) && !imem_valid) pending_nx = redirect_tgt;
      else                                                    pc_nx      = redirect_tgt;
    end else begin
      if (!stall) id_valid_nx = 1'b0;
      unique case (state_q)
        S_FETCH: begin
          if (imem_valid) begin
            if (slot_free) begin
              id_valid_nx    = 1'b1;
              id_instr_nx    = imem_rdata;
              id_pc_plus2_nx = pc_plus2;
              pc_nx          = pc_plus2;
            end else begin
              skid_valid_nx = 1'b1;
              skid_instr_nx = imem_rdata;
              skid_pc2_nx   = pc_plus2;
            end
          end
        end
        S_HOLD: begin
          if (slot_free && skid_valid_q) begin
            id_valid_nx    = 1'b1;
            id_instr_nx    = skid_instr_q;
            id_pc_plus2_nx = skid_pc2_q;
            pc_nx          = pc_plus2;
            skid_valid_nx  = 1'b0;
          end
        end
        S_DRAIN: if (imem_valid) pc_nx = pending_q;
        default: ;
      endcase
    end
    halted_nx    = state_nx == S_HALT;
    imem_req_nx  = (state_nx == S_FETCH) || (state_nx == S_DRAIN);
    imem_addr_nx = imem_req_nx ? pc_nx : '0;
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      pending_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc2_q   <= '0;
      id_valid     <= 1'b0;
      id_instr     <= NOP_INSTR;
      id_pc_plus2  <= '0;
      halted       <= 1'b0;
      imem_req     <= 1'b0;
      imem_addr    <= '0;
    end else begin
      pc_q         <= pc_nx;
      pending_q    <= pending_nx;
      skid_valid_q <= skid_valid_nx;
      skid_instr_q <= skid_instr_nx;
      skid_pc2_q   <= skid_pc2_nx;
      id_valid     <= id_valid_nx;
      id_instr     <= id_instr_nx;
      id_pc_plus2  <= id_pc_plus2_nx;
      halted       <= halted_nx;
      imem_req     <= imem_req_nx;
      imem_addr    <= imem_addr_nx;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory-transaction level model checked every cycle,
// plus literal expectations at the key points of each directed scenario.
module tb_fetch_stage;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst_n, stall, redirect;
  logic [15:0] redirect_pc;
  logic        imem_req, imem_valid;
  logic [15:0] imem_addr, imem_rdata;
  logic        id_valid, halted;
  logic [15:0] id_instr, id_pc_plus2;
  logic [4:0]  id_opcode;
  logic [1:0]  id_funcode;

  logic        w_req, w_valid, w_id_valid, w_halted;
  logic [15:0] w_addr, w_rdata, w_instr, w_pc2;
  logic [4:0]  w_opcode;
  logic [1:0]  w_funcode;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(16'h0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .id_valid(id_valid),
    .id_instr(id_instr), .id_opcode(id_opcode), .id_funcode(id_funcode),
    .id_pc_plus2(id_pc_plus2), .halted(halted)
  );

  fetch_stage #(.RESET_PC(16'hFFFE), .NOP_INSTR(NOP)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rdata(w_rdata), .imem_valid(w_valid), .stall(1'b0),
    .redirect(1'b0), .redirect_pc(16'h0000), .id_valid(w_id_valid),
    .id_instr(w_instr), .id_opcode(w_opcode), .id_funcode(w_funcode),
    .id_pc_plus2(w_pc2), .halted(w_halted)
  );

  assign w_valid = w_req;
  assign w_rdata = 16'h4000 + w_addr;

  // Memory: word = 0x4000+addr (or HALT at halt_addr), response lat cycles after request start
  int unsigned lat;
  int unsigned mem_cnt;
  logic        force_valid, halt_en;
  logic [15:0] halt_addr;

  function automatic logic [15:0] mem_word(input logic [15:0] a, input logic en,
                                           input logic [15:0] ha);
    return (en && a == ha) ? 16'h0000 : 16'h4000 + a;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      mem_cnt <= 0;
    else if (imem_req && !imem_valid) mem_cnt <= mem_cnt + 1;
    else                             mem_cnt <= 0;
  end

  assign imem_valid = force_valid || (imem_req && (mem_cnt + 1 >= lat));
  assign imem_rdata = mem_word(imem_addr, halt_en, halt_addr);

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Model: IF/ID contents, one waiting accepted word, and the fetch address stream
  logic        m_valid, m_halted, m_started, m_q_valid, m_killed;
  logic [15:0] m_instr, m_pc2, m_q_instr, m_q_pc2, m_fetch_pc, m_pend;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  function automatic logic exp_req();
    return m_started && !m_halted && !m_q_valid;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_halted = 1'b0; m_started = 1'b0; m_q_valid = 1'b0; m_killed = 1'b0;
    m_instr = NOP; m_pc2 = 16'h0000; m_q_instr = 16'h0000; m_q_pc2 = 16'h0000;
    m_fetch_pc = 16'h0000; m_pend = 16'h0000;
  endtask

  task automatic model_compare();
    logic r;
    r = exp_req();
    chk("id_valid",    16'(id_valid), 16'(m_valid));
    chk("id_instr",    id_instr, m_instr);
    chk("id_pc_plus2", id_pc_plus2, m_pc2);
    chk("id_opcode",   16'(id_opcode), 16'(m_instr[15:11]));
    chk("id_funcode",  16'(id_funcode), 16'(m_instr[1:0]));
    chk("halted",      16'(halted), 16'(m_halted));
    chk("imem_req",    16'(imem_req), 16'(r));
    chk("imem_addr",   imem_addr, r ? m_fetch_pc : 16'h0000);
  endtask

  task automatic model_step();
    logic        req_now, resp, free, load;
    logic [15:0] tgt, word, ld_instr, ld_pc2;
    req_now  = exp_req();
    resp     = req_now && imem_valid;
    free     = !m_valid || !stall;
    tgt      = redirect_pc & 16'hFFFE;
    word     = mem_word(m_fetch_pc, halt_en, halt_addr);
    load     = 1'b0;
    ld_instr = 16'h0000;
    ld_pc2   = 16'h0000;
    if (redirect) begin
      m_valid = 1'b0; m_instr = NOP; m_q_valid = 1'b0; m_halted = 1'b0;
      if (req_now && !imem_valid) begin
        m_killed = 1'b1; m_pend = tgt;
      end else begin
        m_killed = 1'b0; m_fetch_pc = tgt;
      end
    end else begin
      if (resp && m_killed) begin
        m_fetch_pc = m_pend; m_killed = 1'b0;
      end else if (resp) begin
        if (free) begin
          load = 1'b1; ld_instr = word; ld_pc2 = m_fetch_pc + 16'd2;
        end else begin
          m_q_valid = 1'b1; m_q_instr = word; m_q_pc2 = m_fetch_pc + 16'd2;
        end
        m_fetch_pc = m_fetch_pc + 16'd2;
      end else if (m_q_valid && free) begin
        load = 1'b1; ld_instr = m_q_instr; ld_pc2 = m_q_pc2; m_q_valid = 1'b0;
      end
      if (load) begin
        m_valid = 1'b1; m_instr = ld_instr; m_pc2 = ld_pc2;
        if (ld_instr[15:11] == 5'b00000) m_halted = 1'b1;
      end else if (!stall) begin
        m_valid = 1'b0;
      end
    end
    m_started = 1'b1;
  endtask

  // Check outputs of the previous edge, advance the model, then step past the next edge
  task automatic cycle();
    @(negedge clk);
    if (!rst_n) model_reset();
    model_compare();
    if (rst_n) model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  logic [23:0] stall_pat;

  initial begin
    rst_n = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    force_valid = 1'b0; halt_en = 1'b1; halt_addr = 16'h0008; lat = 1;
    stall_pat = 24'b0110_0011_1000_1101_0010_0111;
    model_reset();
    #2 rst_n = 1'b0;
    cycle(); cycle();
    chk("rst_id_instr", id_instr, 16'h0800);
    chk("rst_id_valid", 16'(id_valid), 16'h0000);
    chk("rst_req", 16'(imem_req), 16'h0000);
    chk("rst_halted", 16'(halted), 16'h0000);

    // Zero-latency streaming from reset
    rst_n = 1'b1;
    chk("start_req", 16'(imem_req), 16'h0000);
    cycle();
    chk("seq_addr0", imem_addr, 16'h0000);
    chk("seq_req0", 16'(imem_req), 16'h0001);
    chk("wrap_addr0", w_addr, 16'hFFFE);
    cycle();
    chk("seq_addr2", imem_addr, 16'h0002);
    chk("seq_pc2_2", id_pc_plus2, 16'h0002);
    chk("seq_instr0", id_instr, 16'h4000);
    chk("wrap_addr1", w_addr, 16'h0000);
    chk("wrap_pc2", w_pc2, 16'h0000);
    chk("wrap_instr", w_instr, 16'h3FFE);
    cycle();
    chk("seq_addr4", imem_addr, 16'h0004);
    chk("seq_pc2_4", id_pc_plus2, 16'h0004);

    // Stall for three cycles while the word at 4 returns
    stall = 1'b1;
    cycle();
    chk("hold_req", 16'(imem_req), 16'h0000);
    chk("hold_addr", imem_addr, 16'h0000);
    chk("hold_instr", id_instr, 16'h4002);
    chk("hold_pc2", id_pc_plus2, 16'h0004);
    cycle(); cycle();
    stall = 1'b0;
    cycle();
    chk("release_instr", id_instr, 16'h4004);
    chk("release_pc2", id_pc_plus2, 16'h0006);
    chk("release_addr", imem_addr, 16'h0006);

    // HALT word at address 8
    cycle();
    cycle();
    chk("halt_valid", 16'(id_valid), 16'h0001);
    chk("halt_opcode", 16'(id_opcode), 16'h0000);
    chk("halt_flag", 16'(halted), 16'h0001);
    chk("halt_req", 16'(imem_req), 16'h0000);
    cycle();
    chk("halt_drain_valid", 16'(id_valid), 16'h0000);
    chk("halt_stays", 16'(halted), 16'h0001);
    redirect = 1'b1; redirect_pc = 16'h0020;
    cycle();
    redirect = 1'b0;
    chk("unhalt_flag", 16'(halted), 16'h0000);
    chk("unhalt_addr", imem_addr, 16'h0020);
    cycle();
    chk("unhalt_instr", id_instr, 16'h4020);

    // Two-cycle memory, redirect in the first request cycle
    lat = 2; redirect = 1'b1; redirect_pc = 16'h0101;
    cycle();
    redirect = 1'b0;
    chk("drain_addr", imem_addr, 16'h0022);
    chk("drain_req", 16'(imem_req), 16'h0001);
    chk("drain_instr", id_instr, NOP);
    cycle();
    chk("drain_new_addr", imem_addr, 16'h0100);
    chk("drain_no_stale", 16'(id_valid), 16'h0000);
    cycle(); cycle();
    chk("drain_first", id_instr, 16'h4100);
    chk("drain_first_pc2", id_pc_plus2, 16'h0102);

    // Three-cycle memory, second redirect while draining replaces the target
    lat = 3; redirect = 1'b1; redirect_pc = 16'h0200;
    cycle();
    redirect_pc = 16'h0300;
    cycle();
    redirect = 1'b0;
    cycle();
    chk("redrain_addr", imem_addr, 16'h0300);

    // Directed stall pattern against two-cycle memory
    lat = 2;
    for (int i = 0; i < 24; i++) begin
      stall = stall_pat[i];
      cycle();
    end

    // Redirect out of HOLD flushes the skid word
    stall = 1'b0; lat = 1;
    cycle(); cycle();
    stall = 1'b1;
    cycle(); cycle();
    redirect = 1'b1; redirect_pc = 16'h0400;
    cycle();
    chk("hold_redir_valid", 16'(id_valid), 16'h0000);
    chk("hold_redir_addr", imem_addr, 16'h0400);
    stall = 1'b0; redirect = 1'b0;
    cycle();
    chk("hold_redir_instr", id_instr, 16'h4400);

    // Redirect with a coincident response, then wrap past 0xFFFE
    redirect = 1'b1; redirect_pc = 16'hFFFD;
    cycle();
    redirect = 1'b0;
    chk("wrap_redir_addr", imem_addr, 16'hFFFC);
    chk("wrap_redir_valid", 16'(id_valid), 16'h0000);
    cycle(); cycle();
    chk("wrap_main_addr", imem_addr, 16'h0000);
    chk("wrap_main_pc2", id_pc_plus2, 16'h0000);
    cycle();

    // Reset mid-request, stray response during START
    lat = 3;
    cycle();
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", 16'(imem_req), 16'h0000);
    chk("async_rst_instr", id_instr, NOP);
    cycle(); cycle();
    rst_n = 1'b1; force_valid = 1'b1;
    cycle();
    force_valid = 1'b0; lat = 1;
    chk("stray_valid", 16'(id_valid), 16'h0000);
    chk("stray_addr", imem_addr, 16'h0000);
    for (int i = 0; i < 8; i++) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
